// File: rtl/chooser_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chooser_select_ctrl
// Description : Operand registers and debounced / auto-alternating select
//               generator feeding a WIDTH-bit 2:1 chooser.
// Revision    : 1.0 - initial release
// ============================================================================
module chooser_select_ctrl #(
    parameter int WIDTH       = 4,
    parameter int DEB_CYCLES  = 4,
    parameter int AUTO_PERIOD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    input  logic             auto_en,
    input  logic             load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             s,
    output logic             toggled
);

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int AUTO_W = $clog2(AUTO_PERIOD);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    mode_e              mode_q, mode_d;
    logic               btn_s1_q, btn_s2_q;
    logic               stable_q, stable_d;
    logic               stable_prev_q;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [AUTO_W-1:0]  auto_cnt_q, auto_cnt_d;
    logic               s_q, s_d;
    logic               toggled_q, toggled_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               press;
    logic               auto_tc;
    logic               toggle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= MODE_MANUAL;
            btn_s1_q      <= 1'b0;
            btn_s2_q      <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            deb_cnt_q     <= '0;
            auto_cnt_q    <= '0;
            s_q           <= 1'b0;
            toggled_q     <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
        end else begin
            mode_q        <= mode_d;
            btn_s1_q      <= btn;
            btn_s2_q      <= btn_s1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            deb_cnt_q     <= deb_cnt_d;
            auto_cnt_q    <= auto_cnt_d;
            s_q           <= s_d;
            toggled_q     <= toggled_d;
            a_q           <= a_d;
            b_q           <= b_d;
        end
    end

    // Debouncer: a differing level must persist DEB_CYCLES edges to be accepted.
    always_comb begin
        deb_cnt_d = '0;
        stable_d  = stable_q;
        if (btn_s2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Mode FSM and select toggling.
    always_comb begin
        mode_d     = auto_en ? MODE_AUTO : MODE_MANUAL;
        press      = stable_q & ~stable_prev_q;
        // The terminal count is ignored on the edge that leaves AUTO so s freezes.
        auto_tc    = (mode_q == MODE_AUTO) && (mode_d == MODE_AUTO) &&
                     (auto_cnt_q == AUTO_LAST);
        toggle     = press | auto_tc;
        auto_cnt_d = '0;
        if ((mode_q == MODE_AUTO) && (mode_d == MODE_AUTO) && !toggle) begin
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
        end
        s_d        = s_q ^ toggle;
        toggled_d  = toggle;
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
            a_d = a_in;
            b_d = b_in;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign s       = s_q;
    assign toggled = toggled_q;

endmodule
`default_nettype wire

// File: tb/tb_chooser_select_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_chooser_select_ctrl
// Description : Self-checking bench for chooser_select_ctrl (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chooser_select_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       auto_en;
    logic       load;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic       toggled;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic       t;
    } exp_t;

    typedef struct packed {
        logic       ld;
        logic [3:0] ai;
        logic [3:0] bi;
        logic [3:0] ea;
        logic [3:0] eb;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vt[5];
    logic [3:0] m_a = 4'h0;
    logic [3:0] m_b = 4'h0;
    logic       m_s = 1'b0;

    chooser_select_ctrl #(
        .WIDTH       (4),
        .DEB_CYCLES  (4),
        .AUTO_PERIOD (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .auto_en (auto_en),
        .load    (load),
        .a_in    (a_in),
        .b_in    (b_in),
        .a       (a),
        .b       (b),
        .s       (s),
        .toggled (toggled)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got {a,b,s,toggled}=%b required %b", nm, act, req);
        end
    endtask

    // Drive one cycle, push the expected post-edge state, then pop and compare.
    task automatic cyc(input logic bt, input logic au, input logic ld,
                       input logic [3:0] ai, input logic [3:0] bi,
                       input logic tg, input string nm);
        exp_t e;
        btn = bt; auto_en = au; load = ld; a_in = ai; b_in = bi;
        if (ld) begin
            m_a = ai;
            m_b = bi;
        end
        if (tg) m_s = ~m_s;
        exp_q.push_back('{a: m_a, b: m_b, s: m_s, t: tg});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(nm, {a, b, s, toggled}, {e.a, e.b, e.s, e.t});
    endtask

    initial begin
        vt[0] = '{ld: 1'b1, ai: 4'b0101, bi: 4'b0010, ea: 4'b0101, eb: 4'b0010};
        vt[1] = '{ld: 1'b0, ai: 4'b1111, bi: 4'b1111, ea: 4'b0101, eb: 4'b0010};
        vt[2] = '{ld: 1'b0, ai: 4'b1010, bi: 4'b0001, ea: 4'b0101, eb: 4'b0010};
        vt[3] = '{ld: 1'b1, ai: 4'b1100, bi: 4'b0011, ea: 4'b1100, eb: 4'b0011};
        vt[4] = '{ld: 1'b1, ai: 4'b0101, bi: 4'b0010, ea: 4'b0101, eb: 4'b0010};

        rst = 1'b1; btn = 1'b0; auto_en = 1'b0; load = 1'b0; a_in = 4'h0; b_in = 4'h0;
        #12;
        check("reset_state", {a, b, s, toggled}, 10'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Operand load / hold table
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, vt[i].ld, vt[i].ai, vt[i].bi, 1'b0, $sformatf("load_vec%0d", i));
            check($sformatf("load_tab%0d", i), {a, b, 2'b00}, {vt[i].ea, vt[i].eb, 2'b00});
        end

        // Clean press: s flips on edge 7 only
        for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, k == 7, $sformatf("press1_e%0d", k));
        for (int k = 1; k <= 8; k++)  cyc(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, $sformatf("rel1_e%0d", k));
        // Second press with a load on the toggle edge
        for (int k = 1; k <= 8; k++)  cyc(1'b1, 1'b0, k == 7, 4'b0011, 4'b1001, k == 7, $sformatf("press2_e%0d", k));
        for (int k = 1; k <= 8; k++)  cyc(1'b0, 1'b0, 1'b0, 4'hE, 4'hE, 1'b0, $sformatf("rel2_e%0d", k));

        // Bounce: H3 L2 H3 (rejected), L3, H4 (accepted at edge 18), L8
        for (int k = 1; k <= 23; k++) begin
            cyc((k <= 3) || (k >= 6 && k <= 8) || (k >= 12 && k <= 15),
                1'b0, 1'b0, 4'h7, 4'h7, k == 18, $sformatf("bounce_e%0d", k));
        end

        // AUTO: entry at k=1, toggles at k=9,17,25; exit at k=28 freezes s
        for (int k = 1; k <= 27; k++) cyc(1'b0, 1'b1, 1'b0, 4'h1, 4'h1, (k == 9) || (k == 17) || (k == 25), $sformatf("auto_e%0d", k));
        for (int k = 28; k <= 40; k++) cyc(1'b0, 1'b0, 1'b0, 4'h1, 4'h1, 1'b0, $sformatf("auto_off_e%0d", k));

        // Collision at k=9, auto at 17/25, mid-period press at 27 restarts period
        for (int k = 1; k <= 44; k++) begin
            cyc((k >= 3 && k <= 12) || (k >= 21 && k <= 28), 1'b1, 1'b0, 4'h2, 4'h2,
                (k == 9) || (k == 17) || (k == 25) || (k == 27) || (k == 35) || (k == 43),
                $sformatf("coll_e%0d", k));
        end
        for (int k = 45; k <= 52; k++) cyc(1'b0, 1'b0, 1'b0, 4'h2, 4'h2, 1'b0, $sformatf("coll_off_e%0d", k));

        // Reset mid-AUTO with s=1 and a=0101
        cyc(1'b0, 1'b1, 1'b1, 4'b0101, 4'b0010, 1'b0, "rst_pre_e1");
        for (int k = 2; k <= 12; k++) cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, k == 9, $sformatf("rst_pre_e%0d", k));
        check("pre_reset_s_a", {a, 5'b0, s}, {4'b0101, 5'b0, 1'b1});
        #3;
        auto_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_reset", {a, b, s, toggled}, 10'b0);
        #2;
        rst = 1'b0;
        m_a = 4'h0; m_b = 4'h0; m_s = 1'b0;
        for (int k = 1; k <= 12; k++) cyc(1'b0, 1'b0, 1'b0, 4'h9, 4'h9, 1'b0, $sformatf("post_rst_e%0d", k));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
